// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-back, write-allocate data cache between the MEM stage and a line-wide memory.
// Latency: a hit is accepted on one edge, looked up the next cycle and answered with a registered strobe two edges after acceptance; misses add writeback/fill round trips.
// Backpressure: is_ready is low outside IDLE; toward memory, mem_req and its payload are held stable until mem_ack / mem_rvalid.
// Optional build macro: DCACHE_STATS_EN adds hit_count / miss_count outputs.
module dmem_cache #(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_input_valid,
    input  logic [31:0]          addr,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          din,
    output logic                 is_ready,
    output logic                 is_output_valid,
    output logic                 is_hit,
    output logic [31:0]          dout,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [LINE_BITS-1:0] mem_rdata,
`ifdef DCACHE_STATS_EN
    input  logic                 mem_rvalid,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`else
    input  logic                 mem_rvalid
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 28 - IDX_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE  = 2'd3;

    logic [1:0]           state_q, state_d;

    // Latched request
    logic [TAG_W-1:0]     req_tag_q;
    logic [IDX_W-1:0]     req_idx_q;
    logic [1:0]           req_off_q;
    logic [31:0]          req_din_q;
    logic                 req_wr_q;
    logic                 miss_q;

    // Line state: valid/dirty are reset, tags and data are not
    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    // Registered CPU response
    logic                 out_vld_q;
    logic                 hit_q;
    logic [31:0]          dout_q;

    logic                 accept;
    logic                 lookup_hit;
    logic                 cmp_hit;
    logic                 cmp_miss;
    logic                 wb_done;
    logic                 fill_done;
    logic [6:0]           word_lsb;
    logic [TAG_W-1:0]     victim_tag;
    logic [LINE_BITS-1:0] cur_line;
    logic [LINE_BITS-1:0] store_line;
    logic [31:0]          cur_word;
    logic                 unused_addr_bits;

    // Byte-lane bits never matter for word accesses
    assign unused_addr_bits = ^addr[1:0];

    assign is_ready   = (state_q == S_IDLE);
    assign accept     = is_input_valid && is_ready && (mem_read || mem_write);

    assign word_lsb   = {req_off_q, 5'b0};
    assign cur_line   = data_q[req_idx_q];
    assign victim_tag = tag_q[req_idx_q];
    assign cur_word   = cur_line[word_lsb +: 32];

    assign lookup_hit = valid_q[req_idx_q] && (victim_tag == req_tag_q);
    assign cmp_hit    = (state_q == S_COMPARE) && lookup_hit;
    assign cmp_miss   = (state_q == S_COMPARE) && !lookup_hit;
    assign wb_done    = (state_q == S_WRITEBACK) && mem_ack;
    assign fill_done  = (state_q == S_ALLOCATE) && mem_rvalid;

    assign is_output_valid = out_vld_q;
    assign is_hit          = hit_q;
    assign dout            = dout_q;

    // Merge the store word into the resident line
    always_comb begin
        store_line = cur_line;
        store_line[word_lsb +: 32] = req_din_q;
    end

    // Next-state: a miss detours through WRITEBACK only when the victim is dirty
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (lookup_hit)
                    state_d = S_IDLE;
                else if (valid_q[req_idx_q] && dirty_q[req_idx_q])
                    state_d = S_WRITEBACK;
                else
                    state_d = S_ALLOCATE;
            end
            S_WRITEBACK: begin
                if (mem_ack) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                if (mem_rvalid) state_d = S_COMPARE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory request is decoded from state so it drops with the async reset
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = '0;
        if (state_q == S_WRITEBACK) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {victim_tag, req_idx_q, 4'b0};
            mem_wdata = cur_line;
        end else if (state_q == S_ALLOCATE) begin
            mem_req   = 1'b1;
            mem_addr  = {req_tag_q, req_idx_q, 4'b0};
        end
    end

    // Control state, request latch, line flags and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            req_tag_q <= '0;
            req_idx_q <= '0;
            req_off_q <= 2'd0;
            req_din_q <= 32'd0;
            req_wr_q  <= 1'b0;
            miss_q    <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
            out_vld_q <= 1'b0;
            hit_q     <= 1'b0;
            dout_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            out_vld_q <= cmp_hit;
            hit_q     <= cmp_hit && !miss_q;
            if (accept) begin
                req_tag_q <= addr[31:4+IDX_W];
                req_idx_q <= addr[4+IDX_W-1:4];
                req_off_q <= addr[3:2];
                req_din_q <= din;
                req_wr_q  <= mem_write;
                miss_q    <= 1'b0;
            end
            if (cmp_hit) begin
                dout_q <= req_wr_q ? req_din_q : cur_word;
                if (req_wr_q) dirty_q[req_idx_q] <= 1'b1;
            end
            if (cmp_miss) miss_q <= 1'b1;
            if (wb_done) dirty_q[req_idx_q] <= 1'b0;
            if (fill_done) begin
                valid_q[req_idx_q] <= 1'b1;
                dirty_q[req_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays: written by store hits and line fills only
    always_ff @(posedge clk) begin
        if (cmp_hit && req_wr_q) data_q[req_idx_q] <= store_line;
        if (fill_done) begin
            data_q[req_idx_q] <= mem_rdata;
            tag_q[req_idx_q]  <= req_tag_q;
        end
    end

`ifdef DCACHE_STATS_EN
    // Statistics: a hit is counted when its first-lookup response is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (cmp_hit && !miss_q) hit_count <= hit_count + 32'd1;
            if (cmp_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: randomized and directed checks of dmem_cache against an abstract line-map model.
// A behavioural memory answers requests after a programmable delay and logs every request it sees.
// Compile with DCACHE_STATS_EN to also check the statistics counters.
module tb_dmem_cache;
    localparam int NS = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         is_input_valid = 1'b0;
    logic [31:0]  addr = 32'd0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  din = 32'd0;
    logic         is_ready, is_output_valid, is_hit;
    logic [31:0]  dout;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         mem_rvalid = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dmem_cache #(.NUM_SETS(NS), .LINE_BITS(128)) dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_read(mem_read), .mem_write(mem_write), .din(din),
        .is_ready(is_ready), .is_output_valid(is_output_valid), .is_hit(is_hit), .dout(dout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;

    // ---------------- behavioural backing memory ----------------
    logic [127:0] bk_mem [int];
    logic         lg_we [$];
    logic [31:0]  lg_addr [$];
    logic [127:0] lg_wd [$];
    int           mem_delay = 0;

    function automatic logic [127:0] default_line(int l);
        logic [127:0] r;
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = (32'(l) * 32'd16 + 32'(w) * 32'd4) ^ 32'h5A00_0000;
        return r;
    endfunction

    function automatic logic [127:0] bk_line(int l);
        if (bk_mem.exists(l)) return bk_mem[l];
        return default_line(l);
    endfunction

    initial begin : responder
        logic         busy;
        int           wait_left;
        logic         cur_we;
        logic [31:0]  cur_addr;
        logic [127:0] cur_wd;
        busy = 1'b0;
        wait_left = 0;
        cur_we = 1'b0;
        cur_addr = 32'd0;
        cur_wd = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rvalid = 1'b0;
            if (!mem_req) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_left = mem_delay;
                    cur_we = mem_we;
                    cur_addr = mem_addr;
                    cur_wd = mem_wdata;
                    lg_we.push_back(mem_we);
                    lg_addr.push_back(mem_addr);
                    lg_wd.push_back(mem_wdata);
                end
                if (wait_left == 0) begin
                    if (cur_we) begin
                        bk_mem[int'(cur_addr >> 4)] = cur_wd;
                        mem_ack = 1'b1;
                    end else begin
                        mem_rdata = bk_line(int'(cur_addr >> 4));
                        mem_rvalid = 1'b1;
                    end
                    busy = 1'b0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- reference model: which line lives in each set ----------------
    logic         m_valid [NS];
    logic         m_dirty [NS];
    int           m_line  [NS];
    logic [127:0] m_dat   [NS];
    logic [127:0] ref_mem [int];
    logic         e_hit, e_wb, e_fill;
    logic [31:0]  e_dout, e_wb_addr, e_fill_addr;
    logic [127:0] e_wb_data;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
            m_line[s] = -1;
        end
    endtask

    task automatic model_access(input logic wr, input logic [31:0] a, input logic [31:0] d);
        int l, s, w;
        l = int'(a >> 4);
        s = l % NS;
        w = int'(a[3:2]);
        e_wb = 1'b0;
        e_fill = 1'b0;
        e_hit = m_valid[s] && (m_line[s] == l);
        if (!e_hit) begin
            if (m_valid[s] && m_dirty[s]) begin
                e_wb = 1'b1;
                e_wb_addr = 32'(m_line[s]) << 4;
                e_wb_data = m_dat[s];
                ref_mem[m_line[s]] = m_dat[s];
            end
            e_fill = 1'b1;
            e_fill_addr = 32'(l) << 4;
            m_dat[s] = ref_mem.exists(l) ? ref_mem[l] : default_line(l);
            m_valid[s] = 1'b1;
            m_line[s] = l;
            m_dirty[s] = 1'b0;
        end
        if (wr) begin
            m_dat[s][w*32 +: 32] = d;
            m_dirty[s] = 1'b1;
            e_dout = d;
        end else begin
            e_dout = m_dat[s][w*32 +: 32];
        end
    endtask

    // ---------------- CPU driver (collects observations, no checks) ----------------
    logic [31:0] got_dout;
    logic        got_hit;
    int          got_lat;

    task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        while (!is_ready && n < 100) begin @(negedge clk); n++; end
        is_input_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; din = d;
        @(posedge clk); #1;
        is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!is_output_valid && n < 500);
        got_lat = n;
        got_dout = is_output_valid ? dout : 32'hxxxx_xxxx;
        got_hit = is_output_valid ? is_hit : 1'bx;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
        model_reset();
        lg_we.delete(); lg_addr.delete(); lg_wd.delete();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++; if (is_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", is_ready); end
        @(negedge clk); @(negedge clk);
        n_checks++; if (is_output_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ovld: got %b want 0", is_output_valid); end
        n_checks++; if (is_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", is_hit); end
        n_checks++; if (dout !== 32'd0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 128'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        #2 reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_cold_load();
        logic pw; logic [31:0] pa;
        bk_mem[16] = {32'd4, 32'd3, 32'd2, 32'd1};
        ref_mem[16] = {32'd4, 32'd3, 32'd2, 32'd1};
        model_access(1'b0, 32'h100, 32'd0);
        cpu_req(1'b1, 1'b0, 32'h100, 32'd0);
        n_checks++; if (lg_we.size() != 1) begin n_fail++; $display("FAIL cold_req_count: got %0d want 1", lg_we.size()); end
        if (lg_we.size() > 0) begin
            pw = lg_we.pop_front(); pa = lg_addr.pop_front(); void'(lg_wd.pop_front());
            n_checks++; if (pw !== 1'b0 || pa !== 32'h100) begin n_fail++; $display("FAIL cold_fill: got we=%b addr=%h want we=0 addr=100", pw, pa); end
        end
        n_checks++; if (got_dout !== 32'd1) begin n_fail++; $display("FAIL cold_dout: got %h want 1", got_dout); end
        n_checks++; if (got_hit !== 1'b0) begin n_fail++; $display("FAIL cold_hit: got %b want 0", got_hit); end
        model_access(1'b0, 32'h10C, 32'd0);
        cpu_req(1'b1, 1'b0, 32'h10C, 32'd0);
        n_checks++; if (got_dout !== 32'd4) begin n_fail++; $display("FAIL rehit_dout: got %h want 4", got_dout); end
        n_checks++; if (got_hit !== 1'b1) begin n_fail++; $display("FAIL rehit_hit: got %b want 1", got_hit); end
        n_checks++; if (got_lat != 2) begin n_fail++; $display("FAIL rehit_latency: got %0d want 2", got_lat); end
        n_checks++; if (lg_we.size() != 0) begin n_fail++; $display("FAIL rehit_traffic: got %0d requests want 0", lg_we.size()); end
    endtask

    task automatic test_store_evict();
        logic pw; logic [31:0] pa; logic [127:0] pd;
        model_access(1'b1, 32'h104, 32'hDEADBEEF);
        cpu_req(1'b0, 1'b1, 32'h104, 32'hDEADBEEF);
        n_checks++; if (got_hit !== 1'b1 || got_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_hit: got hit=%b dout=%h want hit=1 dout=deadbeef", got_hit, got_dout); end
        model_access(1'b0, 32'h504, 32'd0);
        cpu_req(1'b1, 1'b0, 32'h504, 32'd0);
        n_checks++; if (lg_we.size() != 2) begin n_fail++; $display("FAIL evict_req_count: got %0d want 2", lg_we.size()); end
        if (lg_we.size() >= 2) begin
            pw = lg_we.pop_front(); pa = lg_addr.pop_front(); pd = lg_wd.pop_front();
            n_checks++; if (pw !== 1'b1 || pa !== 32'h100 || pd[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL evict_wb: got we=%b addr=%h w1=%h want we=1 addr=100 w1=deadbeef", pw, pa, pd[63:32]); end
            n_checks++; if (pd !== e_wb_data) begin n_fail++; $display("FAIL evict_wb_line: got %h want %h", pd, e_wb_data); end
            pw = lg_we.pop_front(); pa = lg_addr.pop_front(); void'(lg_wd.pop_front());
            n_checks++; if (pw !== 1'b0 || pa !== 32'h500) begin n_fail++; $display("FAIL evict_fill: got we=%b addr=%h want we=0 addr=500", pw, pa); end
        end
        n_checks++; if (got_dout !== e_dout || got_hit !== 1'b0) begin n_fail++; $display("FAIL evict_resp: got dout=%h hit=%b want dout=%h hit=0", got_dout, got_hit, e_dout); end
    endtask

    task automatic test_write_miss();
        logic pw; logic [31:0] pa;
        model_access(1'b1, 32'h208, 32'h55);
        cpu_req(1'b0, 1'b1, 32'h208, 32'h55);
        n_checks++; if (lg_we.size() != 1) begin n_fail++; $display("FAIL wmiss_req_count: got %0d want 1", lg_we.size()); end
        if (lg_we.size() > 0) begin
            pw = lg_we.pop_front(); pa = lg_addr.pop_front(); void'(lg_wd.pop_front());
            n_checks++; if (pw !== 1'b0 || pa !== 32'h200) begin n_fail++; $display("FAIL wmiss_fill: got we=%b addr=%h want we=0 addr=200", pw, pa); end
        end
        n_checks++; if (got_hit !== 1'b0 || got_dout !== 32'h55) begin n_fail++; $display("FAIL wmiss_resp: got hit=%b dout=%h want hit=0 dout=55", got_hit, got_dout); end
        model_access(1'b0, 32'h208, 32'd0);
        cpu_req(1'b1, 1'b0, 32'h208, 32'd0);
        n_checks++; if (got_hit !== 1'b1 || got_dout !== 32'h55) begin n_fail++; $display("FAIL wmiss_reload: got hit=%b dout=%h want hit=1 dout=55", got_hit, got_dout); end
    endtask

    task automatic test_backpressure();
        int resp, wb_cycles;
        logic [127:0] pd; logic [31:0] pa;
        resp = 0; wb_cycles = 0;
        mem_delay = 7;
        model_access(1'b0, 32'h000, 32'd0);
        is_input_valid = 1'b1; mem_read = 1'b1; addr = 32'h000;
        @(posedge clk); #1;
        is_input_valid = 1'b0; mem_read = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (is_output_valid) begin resp++; got_dout = dout; got_hit = is_hit; end
            if (mem_req && mem_we) begin
                wb_cycles++;
                n_checks++; if (mem_addr !== 32'h200 || mem_wdata !== e_wb_data) begin n_fail++; $display("FAIL bp_stable: got addr=%h data=%h want addr=200 data=%h", mem_addr, mem_wdata, e_wb_data); end
                n_checks++; if (is_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", is_ready); end
            end
        end
        mem_delay = 0;
        n_checks++; if (wb_cycles != 8) begin n_fail++; $display("FAIL bp_wb_cycles: got %0d want 8", wb_cycles); end
        n_checks++; if (resp != 1) begin n_fail++; $display("FAIL bp_responses: got %0d want 1", resp); end
        n_checks++; if (got_dout !== e_dout || got_hit !== 1'b0) begin n_fail++; $display("FAIL bp_resp: got dout=%h hit=%b want dout=%h hit=0", got_dout, got_hit, e_dout); end
        n_checks++; if (lg_we.size() != 2) begin n_fail++; $display("FAIL bp_req_count: got %0d want 2", lg_we.size()); end
        if (lg_we.size() > 0) begin
            void'(lg_we.pop_front()); pa = lg_addr.pop_front(); pd = lg_wd.pop_front();
            n_checks++; if (pa !== 32'h200 || pd[95:64] !== 32'h55) begin n_fail++; $display("FAIL bp_wb_word: got addr=%h w2=%h want addr=200 w2=55", pa, pd[95:64]); end
        end
        lg_we.delete(); lg_addr.delete(); lg_wd.delete();
    endtask

    task automatic test_reset_alloc();
        int cnt, resp;
        logic found, pw; logic [31:0] pa;
        cnt = 0; resp = 0; found = 1'b0;
        mem_delay = 20;
        is_input_valid = 1'b1; mem_read = 1'b1; addr = 32'h300;
        @(posedge clk); #1;
        is_input_valid = 1'b0; mem_read = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (is_output_valid) resp++;
            if (mem_req && !mem_we) cnt++;
            if (cnt == 3) found = 1'b1;
        end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL ra_alloc_seen: got %b want 1", found); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ra_mem_req: got %b want 0", mem_req); end
        n_checks++; if (is_ready !== 1'b1) begin n_fail++; $display("FAIL ra_ready: got %b want 1", is_ready); end
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        @(negedge clk);
        if (is_output_valid) resp++;
        n_checks++; if (resp != 0) begin n_fail++; $display("FAIL ra_no_resp: got %0d responses want 0", resp); end
        lg_we.delete(); lg_addr.delete(); lg_wd.delete();
        mem_delay = 0;
        model_access(1'b0, 32'h300, 32'd0);
        cpu_req(1'b1, 1'b0, 32'h300, 32'd0);
        n_checks++; if (got_hit !== 1'b0 || got_dout !== e_dout) begin n_fail++; $display("FAIL ra_remiss: got hit=%b dout=%h want hit=0 dout=%h", got_hit, got_dout, e_dout); end
        n_checks++; if (lg_we.size() != 1) begin n_fail++; $display("FAIL ra_req_count: got %0d want 1", lg_we.size()); end
        if (lg_we.size() > 0) begin
            pw = lg_we.pop_front(); pa = lg_addr.pop_front(); void'(lg_wd.pop_front());
            n_checks++; if (pw !== 1'b0 || pa !== 32'h300) begin n_fail++; $display("FAIL ra_fill: got we=%b addr=%h want we=0 addr=300", pw, pa); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic        w [3];
        a[0] = 32'h304; a[1] = 32'h30C; a[2] = 32'h30C;
        w[0] = 1'b0;    w[1] = 1'b1;    w[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_access(w[i], a[i], 32'hC0DE_0000 + 32'(i));
            cpu_req(!w[i], w[i], a[i], 32'hC0DE_0000 + 32'(i));
            n_checks++; if (got_dout !== e_dout || got_hit !== 1'b1 || got_lat != 2) begin n_fail++; $display("FAIL b2b_%0d: got dout=%h hit=%b lat=%0d want dout=%h hit=1 lat=2", i, got_dout, got_hit, got_lat, e_dout); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, pa;
        logic        wr, rd, pw;
        logic [127:0] pd;
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 47)) << 4) | 32'($urandom_range(0, 15));
            d = $urandom;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_delay = $urandom_range(0, 3);
            model_access(wr, a, d);
            cpu_req(rd, wr, a, d);
            n_checks++; if (got_dout !== e_dout || got_hit !== e_hit) begin n_fail++; $display("FAIL rand_resp[%0d]: addr=%h got dout=%h hit=%b want dout=%h hit=%b", i, a, got_dout, got_hit, e_dout, e_hit); end
            n_checks++; if (lg_we.size() != int'(e_wb) + int'(e_fill)) begin n_fail++; $display("FAIL rand_req_count[%0d]: got %0d want %0d", i, lg_we.size(), int'(e_wb) + int'(e_fill)); end
            if (e_wb && lg_we.size() > 0) begin
                pw = lg_we.pop_front(); pa = lg_addr.pop_front(); pd = lg_wd.pop_front();
                n_checks++; if (pw !== 1'b1 || pa !== e_wb_addr || pd !== e_wb_data) begin n_fail++; $display("FAIL rand_wb[%0d]: got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i, pw, pa, pd, e_wb_addr, e_wb_data); end
            end
            if (e_fill && lg_we.size() > 0) begin
                pw = lg_we.pop_front(); pa = lg_addr.pop_front(); void'(lg_wd.pop_front());
                n_checks++; if (pw !== 1'b0 || pa !== e_fill_addr) begin n_fail++; $display("FAIL rand_fill[%0d]: got we=%b addr=%h want we=0 addr=%h", i, pw, pa, e_fill_addr); end
            end
            if (e_hit) begin
                n_checks++; if (got_lat != 2) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 2", i, got_lat); end
            end
            lg_we.delete(); lg_addr.delete(); lg_wd.delete();
        end
        mem_delay = 0;
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        do_reset();
        n_checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_fail++; $display("FAIL stats_reset: got hits=%0d misses=%0d want 0 0", hit_count, miss_count); end
        cpu_req(1'b1, 1'b0, 32'h000, 32'd0);
        cpu_req(1'b1, 1'b0, 32'h004, 32'd0);
        cpu_req(1'b1, 1'b0, 32'h400, 32'd0);
        cpu_req(1'b1, 1'b0, 32'h000, 32'd0);
        @(negedge clk);
        n_checks++; if (hit_count !== 32'd1) begin n_fail++; $display("FAIL stats_hits: got %0d want 1", hit_count); end
        n_checks++; if (miss_count !== 32'd3) begin n_fail++; $display("FAIL stats_misses: got %0d want 3", miss_count); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_cold_load();
        test_store_evict();
        test_write_miss();
        test_backpressure();
        test_reset_alloc();
        test_back_to_back();
        test_random();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a line-wide backing data memory.
- The MEM stage issues one word load/store at a time and stalls the pipeline while is_ready is low.
- The block exists so the pipeline can run against a multi-cycle memory without changing the MEM/WB register contract.

Parameters:
- NUM_SETS, 16, number of lines; power of two, minimum 2; index = addr[3+log2(NUM_SETS):4].
- LINE_BITS, 128, line width; fixed at 4 words of 32 bits; offset = addr[3:2].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- is_input_valid  input  1  CPU request present this cycle.
- addr  input  32  byte address; addr[1:0] ignored.
- mem_read  input  1  request is a load.
- mem_write  input  1  request is a store.
- din  input  32  store data.
- is_ready  output  1  cache is in IDLE and can accept a request.
- is_output_valid  output  1  one-cycle response strobe.
- is_hit  output  1  the completed request hit on its first lookup; qualified by is_output_valid.
- dout  output  32  load data, or store data echoed back; qualified by is_output_valid.
- mem_req  output  1  backing memory request.
- mem_we  output  1  1 = line writeback, 0 = line fill.
- mem_addr  output  32  line-aligned address; bits [3:0] = 0.
- mem_wdata  output  128  victim line for writeback.
- mem_ack  input  1  memory accepted a writeback (one pulse).
- mem_rdata  input  128  fill line.
- mem_rvalid  input  1  mem_rdata valid (one pulse).

Behaviour:
- Reset values:
  - valid[] = 0, dirty[] = 0, state = IDLE.
  - is_ready = 1, is_output_valid = 0, is_hit = 0, dout = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Tag and data arrays are not reset.
- Acceptance: a request is taken when is_input_valid && is_ready && (mem_read || mem_write). At acceptance, addr, din and the read/write type are latched. If both mem_read and mem_write are high, the request is treated as a store.
- IDLE: on acceptance, go to COMPARE. is_ready = (state == IDLE), combinational.
- COMPARE (the cycle after acceptance):
  - Hit = valid[idx] && tag[idx] == latched tag.
  - Hit, load: dout = selected word.
  - Hit, store: the selected word is written, dirty[idx] = 1, dout = din.
  - On a hit, is_output_valid = 1 for exactly this cycle, is_hit = 1 if no miss occurred for this request, then go to IDLE.
  - Miss with dirty victim: go to WRITEBACK. Miss with clean victim: go to ALLOCATE. In both cases record a miss flag.
- Hit latency: 2 cycles from the acceptance edge to the is_output_valid cycle, with no idle gap. A back-to-back request can be accepted in the cycle after the response.
- WRITEBACK:
  - Drive mem_req = 1, mem_we = 1, mem_addr = {victim tag, idx, 4'b0}, mem_wdata = victim line.
  - Hold all of these stable until mem_ack.
  - On mem_ack: dirty[idx] = 0, go to ALLOCATE.
- ALLOCATE:
  - Drive mem_req = 1, mem_we = 0, mem_addr = {latched tag, idx, 4'b0}.
  - Hold until mem_rvalid.
  - On mem_rvalid: write mem_rdata into the line, set the tag, valid[idx] = 1, dirty[idx] = 0, go to COMPARE. The re-lookup then hits and completes the request, with is_hit = 0.
- mem_req drops in the cycle after mem_ack or mem_rvalid. mem_ack/mem_rvalid seen outside WRITEBACK/ALLOCATE are ignored.
- Word select: word 0 = line[31:0], through word 3 = line[127:96].
- Reset asserted mid-miss: return to IDLE and drop mem_req asynchronously. The in-flight request is discarded with no response.
- One outstanding CPU request and one outstanding memory request at most.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each is_output_valid with is_hit = 1.
  - miss_count increments on each COMPARE miss.
  - Both clear on reset and wrap at 2^32.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Cold load, addr 0x100, memory line 0x100 = {w3..w0} = {4,3,2,1}:
  - One mem_req, mem_we = 0, mem_addr = 0x100.
  - dout = 1, is_hit = 0.
  - Then a load of 0x10C gives dout = 4, is_hit = 1, 2 cycles after acceptance.
- Store-hit then evict: store 0xDEADBEEF to 0x104 (hit), then load 0x504, which maps to the same index for NUM_SETS = 16:
  - The writeback is issued first with mem_addr = 0x100 and mem_wdata[63:32] = 0xDEADBEEF.
  - The fill follows with mem_addr = 0x500.
- Write miss on a clean line, store 0x55 to 0x208:
  - Fill from 0x200, then word 2 = 0x55 and the line is dirty.
  - A load of 0x208 returns 0x55, is_hit = 1.
- Memory backpressure, mem_ack delayed 7 cycles:
  - mem_req, mem_addr and mem_wdata stay stable throughout and is_ready = 0.
  - Exactly one response is produced.
- Reset asserted during ALLOCATE:
  - mem_req = 0 and is_ready = 1 immediately.
  - A load of the same address misses again.
- DCACHE_STATS_EN, sequence load 0x0, load 0x4, load 0x400, load 0x0:
  - hit_count = 1, miss_count = 3.
